aes_round_ctrl: RTL

//  Iterative AES-128 encryption core controller. It owns the 128-bit state register and a

---
 rtl/aes_round_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryption controller, one full round per clock
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int RIDX_W     = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      data_in,
    output logic [RIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      data_out,
    output logic              busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [RIDX_W-1:0] LAST_MID = RIDX_W'(NUM_ROUNDS - 1);
    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4. Row w rotates left by w columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    logic [1:0]        fsm_q, fsm_d;
    logic [RIDX_W-1:0] round_cnt_q, round_cnt_d;
    logic [127:0]      state_q, state_d;
    logic [127:0]      sr_state;

    assign sr_state = shift_rows(sub_bytes(state_q));

    always_comb begin
        fsm_d       = fsm_q;
        round_cnt_d = round_cnt_q;
        state_d     = state_q;
        if (clear) begin
            fsm_d       = ST_IDLE;
            round_cnt_d = '0;
            state_d     = '0;
        end else begin
            case (fsm_q)
                ST_IDLE: if (in_valid) begin
                    state_d     = data_in ^ rk;
                    round_cnt_d = RIDX_W'(1);
                    fsm_d       = (NUM_ROUNDS == 1) ? ST_FINAL : ST_ROUND;
                end
                ST_ROUND: begin
                    state_d     = mix_columns(sr_state) ^ rk;
                    round_cnt_d = round_cnt_q + RIDX_W'(1);
                    if (round_cnt_q == LAST_MID) fsm_d = ST_FINAL;
                end
                ST_FINAL: begin
                    state_d = sr_state ^ rk;
                    fsm_d   = ST_DONE;
                end
                default: if (out_ready) begin
                    fsm_d       = ST_IDLE;
                    round_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q       <= ST_IDLE;
            round_cnt_q <= '0;
            state_q     <= '0;
        end else begin
            fsm_q       <= fsm_d;
            round_cnt_q <= round_cnt_d;
            state_q     <= state_d;
        end
    end

    // Key index depends only on flops so the key store sees a glitch-free address.
    always_comb begin
        rk_idx = '0;
        case (fsm_q)
            ST_ROUND: rk_idx = round_cnt_q;
            ST_FINAL: rk_idx = LAST_IDX;
            default:  rk_idx = '0;
        endcase
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
    assign data_out  = state_q;
endmodule
